// File: rtl/delay_line_pkg.sv
// rtl/delay_line_pkg.sv - default sizing and latency constants for the delay line
package delay_line_pkg;

    localparam int DEPTH        = 16;
    localparam int SEL_WIDTH    = 4;
    localparam int PWM_WIDTH    = 8;
    localparam int PWM_DUTY     = 128;
    // tap register plus output register
    localparam int DELAY_OFFSET = 2;

endpackage

// File: rtl/pwm_gen.sv
// rtl/pwm_gen.sv - free-running PWM test pattern, high for PWM_DUTY of every 2**PWM_WIDTH cycles
module pwm_gen
    import delay_line_pkg::*;
#(
    parameter int PWM_WIDTH = delay_line_pkg::PWM_WIDTH,
    parameter int PWM_DUTY  = delay_line_pkg::PWM_DUTY
) (
    input  logic clk,
    input  logic rst_n,
    output logic pwm
);

    // One extra bit so a duty of 2**PWM_WIDTH compares as always-high.
    localparam logic [PWM_WIDTH:0]   DUTY_W = PWM_DUTY[PWM_WIDTH:0];
    localparam logic [PWM_WIDTH-1:0] ONE    = 1;

    logic [PWM_WIDTH-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            pwm <= 1'b0;
        end else begin
            cnt <= cnt + ONE;
            pwm <= ({1'b0, cnt} < DUTY_W);
        end
    end

endmodule

// File: rtl/delay_line.sv
// rtl/delay_line.sv - programmable tap delay line (DelaySelect + 2 cycles) with optional PWM source
// PWM generator compiled in only when DELAY_LINE_PWM_EN is defined; otherwise PWM is tied low.
module delay_line
    import delay_line_pkg::*;
#(
    parameter int DEPTH     = delay_line_pkg::DEPTH,
    parameter int SEL_WIDTH = delay_line_pkg::SEL_WIDTH,
    parameter int PWM_WIDTH = delay_line_pkg::PWM_WIDTH,
    parameter int PWM_DUTY  = delay_line_pkg::PWM_DUTY
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [SEL_WIDTH-1:0] DelaySelect,
    input  logic                 SignalIn,
    output logic                 SignalOut,
    output logic                 PWM
);

    logic [DEPTH-1:0] tap;

    // Select is used live so a change takes effect on the very next edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tap       <= '0;
            SignalOut <= 1'b0;
        end else begin
            tap       <= {tap[DEPTH-2:0], SignalIn};
            SignalOut <= tap[DelaySelect];
        end
    end

`ifdef DELAY_LINE_PWM_EN
    pwm_gen #(
        .PWM_WIDTH (PWM_WIDTH),
        .PWM_DUTY  (PWM_DUTY)
    ) u_pwm_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .pwm   (PWM)
    );
`else
    assign PWM = 1'b0;
`endif

endmodule

// File: tb/tb_delay_line.sv
// tb/tb_delay_line.sv - table-driven scoreboard bench for delay_line
module tb_delay_line;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] DelaySelect = '0;
    logic       SignalIn = 1'b0;
    logic       SignalOut;
    logic       PWM;

    always #5 clk = ~clk;

    delay_line dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .DelaySelect (DelaySelect),
        .SignalIn    (SignalIn),
        .SignalOut   (SignalOut),
        .PWM         (PWM)
    );

    typedef struct {
        logic [3:0] sel;
        int         lat;
        bit         loop;
        int         ncyc;
    } vec_t;

    int   total = 0;
    int   bad = 0;
    int   ones = 0;
    logic exp_q[$];
    logic hist[$];
    vec_t tbl[32];
    int   lat_tab[16] = '{2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 16, 17};

    task automatic check(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic exp_pwm(input int n);
`ifdef DELAY_LINE_PWM_EN
        return (((n - 1) % 256) < 128);
`else
        return 1'b0;
`endif
    endfunction

    task automatic pop_check();
        logic e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("signalout", SignalOut, e);
            if (SignalOut === 1'b1) ones++;
            check("pwm", PWM, exp_pwm(hist.size()));
        end
    endtask

    // Called at a negedge: drive, predict, clock one edge, compare at next negedge.
    task automatic cycle(input logic s, input logic [3:0] d, input int lat);
        int idx;
        SignalIn    = s;
        DelaySelect = d;
        idx = hist.size() + 1 - lat;
        exp_q.push_back(idx >= 0 ? hist[idx] : 1'b0);
        hist.push_back(s);
        @(posedge clk);
        @(negedge clk);
        pop_check();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("async_rst_out", SignalOut, 1'b0);
        check("async_rst_pwm", PWM, 1'b0);
        for (int i = 0; i < 10; i++) begin
            SignalIn = 1'($urandom_range(0, 1));
            @(posedge clk);
            @(negedge clk);
            check("rst_out", SignalOut, 1'b0);
            check("rst_pwm", PWM, 1'b0);
        end
        exp_q.delete();
        hist.delete();
        rst_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            tbl[i].sel  = 4'(i);
            tbl[i].lat  = lat_tab[i];
            tbl[i].loop = 1'b1;
            tbl[i].ncyc = 256;
        end
        for (int i = 16; i < 32; i++) begin
            tbl[i].sel  = 4'($urandom_range(0, 15));
            tbl[i].lat  = lat_tab[tbl[i].sel];
            tbl[i].loop = 1'b0;
            tbl[i].ncyc = 40;
        end

        @(negedge clk);
        do_reset();

        for (int r = 0; r < 32; r++)
            for (int c = 0; c < tbl[r].ncyc; c++)
                cycle(tbl[r].loop ? PWM : 1'($urandom_range(0, 1)), tbl[r].sel, tbl[r].lat);

        // single one-cycle pulse through tap 7
        for (int i = 0; i < 20; i++) cycle(1'b0, 4'd7, 9);
        ones = 0;
        cycle(1'b1, 4'd7, 9);
        for (int i = 0; i < 20; i++) cycle(1'b0, 4'd7, 9);
        check_int("pulse_count", ones, 1);

        // steady 1 with select jump 0 -> 15
        for (int i = 0; i < 20; i++) cycle(1'b1, 4'd0, 2);
        ones = 0;
        for (int i = 0; i < 10; i++) cycle(1'b1, 4'd15, 17);
        check_int("sel_change_ones", ones, 10);

        // reset mid-stream while SignalOut is high, then history must be gone
        do_reset();
        for (int i = 0; i < 12; i++) cycle(1'b1, 4'd3, 5);
        for (int i = 0; i < 8; i++) cycle(1'($urandom_range(0, 1)), 4'd3, 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
